// File: rtl/video_timing_pkg.sv
// Shared timing constants and encodings for the luma video source.
//  - Default 1600x900 raster timing (active, front porch, sync, back porch) and totals.
//  - Counter widths for the horizontal (11-bit) and vertical (10-bit) position.
//  - Test-pattern select encodings and the source FSM state type.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 1600;
    localparam int unsigned H_FP_DEF     = 48;
    localparam int unsigned H_SYNC_DEF   = 32;
    localparam int unsigned H_BP_DEF     = 80;
    localparam int unsigned V_ACTIVE_DEF = 900;
    localparam int unsigned V_FP_DEF     = 3;
    localparam int unsigned V_SYNC_DEF   = 5;
    localparam int unsigned V_BP_DEF     = 18;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned HCNT_W = 11;
    localparam int unsigned VCNT_W = 10;

    localparam logic [1:0] PAT_SOLID   = 2'd0;
    localparam logic [1:0] PAT_HRAMP   = 2'd1;
    localparam logic [1:0] PAT_VRAMP   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } src_state_e;

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational synthetic luma pattern generator.
// Configuration macro: VIDEO_SRC_CHECKER_EN enables the 8x8 checkerboard on pattern 3;
// without it pattern 3 produces 0x00.
// Ports:
//  h_i          in  8  low byte of the horizontal position
//  v_i          in  8  low byte of the vertical position
//  frame_cnt_i  in  8  low byte of the completed-frame counter
//  pat_i        in  2  pattern select (PAT_* encodings)
//  y_o          out 8  luma for this position (not gated by data valid)
module video_pattern_gen
    import video_timing_pkg::*;
(
    input  logic [7:0] h_i,
    input  logic [7:0] v_i,
    input  logic [7:0] frame_cnt_i,
    input  logic [1:0] pat_i,
    output logic [7:0] y_o
);

    // Only the low bytes matter: the ramps wrap at 8 bits and the checker uses bit 3.
    always_comb begin
        y_o = 8'h00;
        unique case (pat_i)
            PAT_SOLID:   y_o = 8'h80;
            PAT_HRAMP:   y_o = h_i + frame_cnt_i;
            PAT_VRAMP:   y_o = v_i + frame_cnt_i;
            PAT_CHECKER: begin
`ifdef VIDEO_SRC_CHECKER_EN
                y_o = (h_i[3] ^ v_i[3]) ? 8'hFF : 8'h00;
`else
                y_o = 8'h00;
`endif
            end
            default:     y_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/video_stream_src.sv
// Luma video stream source: raster timing counters, run/idle FSM and registered outputs
// feeding the 2D FIR filter. Starts and stops only on frame boundaries.
// Configuration macro: VIDEO_SRC_CHECKER_EN (passed through to video_pattern_gen).
// Ports:
//  clk          in   1  pixel clock
//  rst          in   1  synchronous active-high reset
//  en_i         in   1  run request, honoured in idle and at the last clock of a frame
//  pat_sel_i    in   2  pattern select, latched at pixel (0,0)
//  y_o          out  8  luma, 0x00 outside the active area
//  dv_o         out  1  data valid (active area)
//  hs_o         out  1  horizontal sync, polarity per SYNC_POL
//  vs_o         out  1  vertical sync (whole lines), polarity per SYNC_POL
//  sof_o        out  1  pulse with pixel (0,0)
//  frame_cnt_o  out 16  completed-frame counter
module video_stream_src
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [1:0]  pat_sel_i,
    output logic [7:0]  y_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        sof_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCNT_W-1:0] HLast     = HCNT_W'(HTotal - 1);
    localparam logic [HCNT_W-1:0] HAct      = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HSyncBeg  = HCNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCNT_W-1:0] HSyncEnd  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCNT_W-1:0] VLast     = VCNT_W'(VTotal - 1);
    localparam logic [VCNT_W-1:0] VAct      = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VSyncBeg  = VCNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCNT_W-1:0] VSyncEnd  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

    src_state_e          state_q, state_d;
    logic [HCNT_W-1:0]   h_q, h_d;
    logic [VCNT_W-1:0]   v_q, v_d;
    logic [15:0]         fc_q, fc_d;
    logic [1:0]          pat_q, pat_d;

    logic [7:0]          y_q, y_d;
    logic                dv_q, dv_d;
    logic                hs_q, hs_d;
    logic                vs_q, vs_d;
    logic                sof_q, sof_d;

    logic                run;
    logic                at_origin;
    logic [1:0]          pat_eff;
    logic [7:0]          pat_y;

    assign run       = (state_q == StRun);
    assign at_origin = (h_q == '0) && (v_q == '0);
    // Pixel (0,0) must already use the newly selected pattern, so bypass pat_q there.
    assign pat_eff   = at_origin ? pat_sel_i : pat_q;

    video_pattern_gen u_pattern_gen (
        .h_i         (h_q[7:0]),
        .v_i         (v_q[7:0]),
        .frame_cnt_i (fc_q[7:0]),
        .pat_i       (pat_eff),
        .y_o         (pat_y)
    );

    // Next-state: FSM and raster counters.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        fc_d    = fc_q;
        pat_d   = pat_q;
        unique case (state_q)
            StIdle: begin
                h_d = '0;
                v_d = '0;
                if (en_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                pat_d = pat_eff;
                if (h_q == HLast) begin
                    h_d = '0;
                    if (v_q == VLast) begin
                        v_d  = '0;
                        fc_d = fc_q + 16'd1;
                        if (!en_i) begin
                            state_d = StIdle;
                        end
                    end else begin
                        v_d = v_q + VCNT_W'(1);
                    end
                end else begin
                    h_d = h_q + HCNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode of the current counters; registered below, hence the one-clock lag.
    always_comb begin
        dv_d  = run && (h_q < HAct) && (v_q < VAct);
        hs_d  = run && (h_q >= HSyncBeg) && (h_q < HSyncEnd);
        vs_d  = run && (v_q >= VSyncBeg) && (v_q < VSyncEnd);
        sof_d = run && at_origin;
        y_d   = dv_d ? pat_y : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
            fc_q    <= '0;
            pat_q   <= PAT_SOLID;
            y_q     <= 8'h00;
            dv_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fc_q    <= fc_d;
            pat_q   <= pat_d;
            y_q     <= y_d;
            dv_q    <= dv_d;
            hs_q    <= SYNC_POL ? hs_d : ~hs_d;
            vs_q    <= SYNC_POL ? vs_d : ~vs_d;
            sof_q   <= sof_d;
        end
    end

    assign y_o         = y_q;
    assign dv_o        = dv_q;
    assign hs_o        = hs_q;
    assign vs_o        = vs_q;
    assign sof_o       = sof_q;
    assign frame_cnt_o = fc_q;

endmodule

// File: tb/tb_video_stream_src.sv
// Bench for video_stream_src on a reduced raster (260x12 active) so whole frames are cheap.
// Two instances: active-high syncs and active-low syncs, sharing all inputs.
module tb_video_stream_src;

    localparam int HA = 260;
    localparam int HF = 4;
    localparam int HS = 3;
    localparam int HB = 5;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

`ifdef VIDEO_SRC_CHECKER_EN
    localparam logic [7:0] CHK_ON = 8'hFF;
`else
    localparam logic [7:0] CHK_ON = 8'h00;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  pat_sel;
    logic [7:0]  y0, y1;
    logic        dv0, dv1, hs0, hs1, vs0, vs1, sof0, sof1;
    logic [15:0] fc0, fc1;

    int n_total = 0;
    int n_bad   = 0;
    int dv_total = 0;
    int vs_total = 0;

    typedef struct packed {
        logic [15:0] fc;
        logic [7:0]  y;
        logic        dv;
        logic        hs;
        logic        vs;
        logic        sof;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit          m_run = 1'b0;
    int          m_h   = 0;
    int          m_v   = 0;
    logic [15:0] m_fc  = 16'd0;
    int          m_pat = 0;

    video_stream_src #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .pat_sel_i   (pat_sel),
        .y_o         (y0),
        .dv_o        (dv0),
        .hs_o        (hs0),
        .vs_o        (vs0),
        .sof_o       (sof0),
        .frame_cnt_o (fc0)
    );

    video_stream_src #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) u_dut_n (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .pat_sel_i   (pat_sel),
        .y_o         (y1),
        .dv_o        (dv1),
        .hs_o        (hs1),
        .vs_o        (vs1),
        .sof_o       (sof1),
        .frame_cnt_o (fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat_y(int h, int v, int pat, int fc);
        case (pat)
            0:       return 8'h80;
            1:       return 8'((h + fc) % 256);
            2:       return 8'((v + fc) % 256);
            default: begin
`ifdef VIDEO_SRC_CHECKER_EN
                return ((((h / 8) + (v / 8)) % 2) == 1) ? 8'hFF : 8'h00;
`else
                return 8'h00;
`endif
            end
        endcase
    endfunction

    function automatic exp_t model_out(bit run, int h, int v, int pat, logic [15:0] fc_now,
                                       logic [15:0] fc_next);
        exp_t e;
        e    = '0;
        e.fc = fc_next;
        if (run) begin
            e.dv  = (h < HA) && (v < VA);
            e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
            e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
            e.sof = (h == 0) && (v == 0);
            if (e.dv) e.y = pat_y(h, v, pat, int'(fc_now));
        end
        return e;
    endfunction

    // Model: at each edge push what the DUT outputs should hold after that edge.
    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_h   <= 0;
            m_v   <= 0;
            m_fc  <= 16'd0;
            m_pat <= 0;
            sb.push_back(exp_t'('0));
        end else begin
            sb.push_back(model_out(m_run, m_h, m_v,
                                   (m_h == 0 && m_v == 0) ? int'(pat_sel) : m_pat, m_fc,
                                   (m_run && m_h == HT - 1 && m_v == VT - 1) ? m_fc + 16'd1
                                                                            : m_fc));
            if (!m_run) begin
                m_h <= 0;
                m_v <= 0;
                if (en) m_run <= 1'b1;
            end else begin
                if (m_h == 0 && m_v == 0) m_pat <= int'(pat_sel);
                if (m_h == HT - 1) begin
                    m_h <= 0;
                    if (m_v == VT - 1) begin
                        m_v  <= 0;
                        m_fc <= m_fc + 16'd1;
                        if (!en) m_run <= 1'b0;
                    end else begin
                        m_v <= m_v + 1;
                    end
                end else begin
                    m_h <= m_h + 1;
                end
            end
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            check("sb_pos", {4'h0, fc0, y0, dv0, hs0, vs0, sof0}, {4'h0, sb[0]});
            check("sb_neg", {4'h0, fc1, y1, dv1, hs1, vs1, sof1},
                  {4'h0, sb[0].fc, sb[0].y, sb[0].dv, ~sb[0].hs, ~sb[0].vs, sb[0].sof});
            sb.delete(0);
        end
    end

    // Activity monitor for frame-level totals.
    always @(posedge clk) begin
        #1;
        if (dv0 === 1'b1) dv_total <= dv_total + 1;
        if (vs0 === 1'b1) vs_total <= vs_total + 1;
    end

    task automatic wait_sof(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sof0 !== 1'b1 && n < 2 * HT * VT);
        check("sof_seen", 32'(sof0), 32'd1);
    endtask

    task automatic wait_fc(input logic [15:0] target);
        int n;
        n = 0;
        while (fc0 !== target && n < 2 * HT * VT) begin
            @(negedge clk);
            n++;
        end
        check("fc_reach", 32'(fc0), 32'(target));
    endtask

    initial begin
        int n;
        int dv_n;
        int hs_n;
        int hs_first;

        rst     = 1'b1;
        en      = 1'b0;
        pat_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_y", 32'(y0), 32'h0);
        check("rst_dv", 32'(dv0), 32'd0);
        check("rst_hs", 32'(hs0), 32'd0);
        check("rst_vs", 32'(vs0), 32'd0);
        check("rst_hs_n", 32'(hs1), 32'd1);
        check("rst_vs_n", 32'(vs1), 32'd1);
        check("rst_fc", 32'(fc0), 32'd0);

        rst     = 1'b0;
        pat_sel = 2'd1;
        repeat (2) @(negedge clk);
        check("idle_dv", 32'(dv0), 32'd0);

        // en high for one clock; the frame runs to completion regardless.
        en = 1'b1;
        @(negedge clk);
        check("lat1_dv", 32'(dv0), 32'd0);
        en = 1'b0;
        @(negedge clk);
        check("lat2_dv", 32'(dv0), 32'd1);
        check("lat2_sof", 32'(sof0), 32'd1);
        check("lat2_y", 32'(y0), 32'h00);

        dv_n     = 1;
        hs_n     = 0;
        hs_first = -1;
        for (int col = 1; col < HT; col++) begin
            @(negedge clk);
            if (col <= 256) check("ramp", 32'(y0), 32'(col % 256));
            if (dv0 === 1'b1) dv_n++;
            if (hs0 === 1'b1) begin
                hs_n++;
                if (hs_first < 0) hs_first = col;
            end
        end
        check("line_dv_cnt", 32'(dv_n), 32'(HA));
        check("hs_first", 32'(hs_first), 32'(HA + HF));
        check("hs_width", 32'(hs_n), 32'(HS));
        @(negedge clk);
        check("line2_dv", 32'(dv0), 32'd1);
        check("line2_sof", 32'(sof0), 32'd0);
        check("line2_y", 32'(y0), 32'h00);

        wait_fc(16'd1);
        @(negedge clk);
        check("f0_dv_total", 32'(dv_total), 32'(HA * VA));
        check("f0_vs_total", 32'(vs_total), 32'(HT * VS));
        repeat (50) @(negedge clk);
        check("idle_dv_total", 32'(dv_total), 32'(HA * VA));
        check("idle_fc", 32'(fc0), 32'd1);

        // Restart: frame counter continues, ramp shifted by one.
        en = 1'b1;
        wait_sof(n);
        check("f1_latency", 32'(n), 32'd2);
        check("f1_first_y", 32'(y0), 32'h01);
        repeat (3 * HT) @(negedge clk);
        pat_sel = 2'd0;
        wait_sof(n);
        check("frame_period", 32'(n + 3 * HT), 32'(HT * VT));
        check("f2_fc", 32'(fc0), 32'd2);
        check("f2_solid", 32'(y0), 32'h80);
        repeat (100) @(negedge clk);
        pat_sel = 2'd2;
        wait_sof(n);
        check("f3_vramp0", 32'(y0), 32'h03);
        repeat (HT) @(negedge clk);
        check("f3_vramp1", 32'(y0), 32'h04);

        // Abort mid-frame at pixel (130,6).
        repeat (5 * HT + 130) @(negedge clk);
        check("pre_rst_dv", 32'(dv0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dv", 32'(dv0), 32'd0);
        check("mid_rst_y", 32'(y0), 32'h00);
        check("mid_rst_fc", 32'(fc0), 32'd0);
        check("mid_rst_hs_n", 32'(hs1), 32'd1);
        pat_sel = 2'd3;
        en      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_sof(n);
        check("chk_0_0", 32'(y0), 32'h00);
        repeat (8) @(negedge clk);
        check("chk_8_0", 32'(y0), 32'(CHK_ON));
        repeat (8 * HT - 8) @(negedge clk);
        check("chk_0_8", 32'(y0), 32'(CHK_ON));
        repeat (8) @(negedge clk);
        check("chk_8_8", 32'(y0), 32'h00);
        en = 1'b0;
        wait_fc(16'd1);
        repeat (20) @(negedge clk);
        check("end_idle_dv", 32'(dv0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
